// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button conditioning, arbitration, IDLE/WORK/PAUSE FSM, tick prescaler.
// Define DEBOUNCE_EN to insert the per-button debounce filter after the synchronisers.
module stopwatch_ctrl #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 20,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_fStart,
  input  logic       i_fStop,
  input  logic       i_fRecord,
  output logic [1:0] o_State,
  output logic       o_fRun,
  output logic       o_fTick,
  output logic       o_fClear,
  output logic       o_fRecord,
  output logic       o_fCmdDrop
);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE = 2'b00, WORK = 2'b01, PAUSE = 2'b10} state_t;

  state_t        state;
  state_t        next_state;
  logic          clear_next;
  logic          record_next;
  logic [2:0]    btn_raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    level;
  logic [2:0]    hist;
  logic [2:0]    armed;
  logic [2:0]    press;
  logic [1:0]    warm;
  logic          do_stop;
  logic          do_start;
  logic          do_rec;
  logic          drop;
  logic [PW-1:0] presc;

  // bit 2 = Stop, bit 1 = Start, bit 0 = Record (also the priority order)
  assign btn_raw = {i_fStop, i_fStart, i_fRecord};
  assign o_State = state;

  // two-flop synchronisers; warm marks when sync2 reflects real pin levels again
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
      warm  <= 2'b00;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      warm  <= {warm[0], 1'b1};
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
  logic [DW-1:0] db_cnt [3];

  // debounce: level flips only after DB_CYCLES consecutive disagreeing samples
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      level <= 3'b111;
      for (int i = 0; i < 3; i++) db_cnt[i] <= {DW{1'b0}};
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= {DW{1'b0}};
        end else if (db_cnt[i] == DB_LAST) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= {DW{1'b0}};
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end
`else
  assign level = sync2;
`endif

  // falling-edge detect; a button is armed only once seen released, so a press held through reset is ignored
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      hist  <= 3'b111;
      armed <= 3'b000;
      press <= 3'b000;
    end else begin
      hist  <= level;
      armed <= armed | ({3{warm[1]}} & level & sync2);
      press <= armed & hist & ~level;
    end
  end

  // fixed-priority arbitration; every losing press counts as a drop
  always_comb begin
    do_stop  = press[2];
    do_start = press[1] & ~press[2];
    do_rec   = press[0] & ~press[1] & ~press[2];
    drop     = (press[2] & (press[1] | press[0])) | (press[1] & press[0]);
  end

  // next-state and strobe decode
  always_comb begin
    next_state  = state;
    clear_next  = 1'b0;
    record_next = 1'b0;
    case (state)
      IDLE: begin
        if (do_start) next_state = WORK;
        else          next_state = IDLE;
      end
      WORK: begin
        if (do_stop) begin
          next_state = IDLE;
          clear_next = 1'b1;
        end else if (do_start) begin
          next_state = PAUSE;
        end else if (do_rec) begin
          record_next = 1'b1;
        end else begin
          next_state = WORK;
        end
      end
      PAUSE: begin
        if (do_stop) begin
          next_state = IDLE;
          clear_next = 1'b1;
        end else if (do_start) begin
          next_state = WORK;
        end else if (do_rec) begin
          record_next = 1'b1;
        end else begin
          next_state = PAUSE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // mode register and registered strobes
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state      <= IDLE;
      o_fRun     <= 1'b0;
      o_fClear   <= 1'b0;
      o_fRecord  <= 1'b0;
      o_fCmdDrop <= 1'b0;
    end else begin
      state      <= next_state;
      o_fRun     <= (next_state == WORK);
      o_fClear   <= clear_next;
      o_fRecord  <= record_next;
      o_fCmdDrop <= drop;
    end
  end

  // prescaler: counts in WORK, keeps its phase in PAUSE, zero in IDLE
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      presc   <= {PW{1'b0}};
      o_fTick <= 1'b0;
    end else begin
      o_fTick <= (state == WORK) && (presc == PRE_MAX);
      case (state)
        WORK:    presc <= (presc == PRE_MAX) ? {PW{1'b0}} : presc + PW'(1);
        PAUSE:   presc <= presc;
        default: presc <= {PW{1'b0}};
      endcase
    end
  end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: expected output vectors are queued per cycle as stimulus
// is driven and compared on the falling edge. Works with and without DEBOUNCE_EN.
module tb_stopwatch_ctrl;
  localparam int CLK_HZ    = 100;
  localparam int TICK_HZ   = 10;
  localparam int DB_CYCLES = 4;
  localparam int TICK_DIV  = CLK_HZ / TICK_HZ;
`ifdef DEBOUNCE_EN
  localparam int LAT = DB_CYCLES + 3;
`else
  localparam int LAT = 3;
`endif
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_WORK  = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       f_start = 1'b1;
  logic       f_stop = 1'b1;
  logic       f_record = 1'b1;
  logic [1:0] state;
  logic       run, tick, clear, record, cmd_drop;

  stopwatch_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DB_CYCLES(DB_CYCLES)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_fStart(f_start), .i_fStop(f_stop), .i_fRecord(f_record),
    .o_State(state), .o_fRun(run), .o_fTick(tick), .o_fClear(clear), .o_fRecord(record),
    .o_fCmdDrop(cmd_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [6:0] mask;
    logic [6:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  logic done = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", tag, cyc, obs, expv);
    end
  endtask

  function automatic logic [6:0] ev(input logic [1:0] st, input logic tk, input logic clr,
                                    input logic rec, input logic drp);
    return {st, (st == S_WORK), tk, clr, rec, drp};
  endfunction

  task automatic push_exp(input int c, input string tag, input logic [6:0] mask, input logic [6:0] val);
    exp_t e;
    int   i;
    e.c = c; e.tag = tag; e.mask = mask; e.val = val;
    i = sb.size();
    while (i > 0 && sb[i-1].c > c) i--;
    sb.insert(i, e);
  endtask

  // every cycle c0..c1 in state st; in WORK ticks land every TICK_DIV cycles after origin
  task automatic expect_window(input int c0, input int c1, input string tag, input logic [1:0] st,
                               input int origin);
    for (int c = c0; c <= c1; c++)
      push_exp(c, tag, 7'h7F,
               ev(st, (st == S_WORK) && (c > origin) && ((c - origin) % TICK_DIV == 0),
                  1'b0, 1'b0, 1'b0));
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // align so the command lands when (landing cycle - origin) mod TICK_DIV == target
  task automatic wait_phase(input int origin, input int target);
    while (((cyc + 1 + LAT - origin) % TICK_DIV) != target) @(negedge clk);
  endtask

  // scoreboard drain on the falling edge
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.c < cyc)
        check_eq({mon_e.tag, "_late"}, cyc, mon_e.c);
      else
        check_eq(mon_e.tag, {25'd0, {state, run, tick, clear, record, cmd_drop} & mon_e.mask},
                 {25'd0, mon_e.val & mon_e.mask});
    end
  end

  initial begin
    #200000;
    if (!done) begin
      check_eq("timeout", {31'd0, done}, 32'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  int w, r, p, q, w2, s, g, w3, p3, k, q3;

  initial begin
    // reset state
    @(negedge clk);
    expect_window(cyc + 1, cyc + 3, "reset", S_IDLE, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    expect_window(cyc + 1, cyc + 8, "idle_after_rst", S_IDLE, 0);
    repeat (8) @(negedge clk);

    // Start held 10 cycles: exact latency, then 5 ticks in 50 cycles
    f_start = 1'b0;
    w = cyc + 1 + LAT;
    expect_window(cyc + 1, w - 1, "start_latency", S_IDLE, 0);
    expect_window(w, w + 50, "work_ticks", S_WORK, w);
    repeat (10) @(negedge clk);
    f_start = 1'b1;
    wait_until(w + 50);

    // Record landing on a tick cycle: both strobes together, state stays WORK
    wait_phase(w, 0);
    f_record = 1'b0;
    r = cyc + 1 + LAT;
    expect_window(cyc + 1, r - 1, "rec_pre", S_WORK, w);
    push_exp(r, "rec_with_tick", 7'h7F, ev(S_WORK, 1'b1, 1'b0, 1'b1, 1'b0));
    expect_window(r + 1, r + 5, "rec_post", S_WORK, w);
    repeat (6) @(negedge clk);
    f_record = 1'b1;
    wait_until(r + 8);

    // Start -> PAUSE with prescaler phase 4, no ticks for 30 cycles
    wait_phase(w, 4);
    f_start = 1'b0;
    p = cyc + 1 + LAT;
    expect_window(cyc + 1, p - 1, "pause_pre", S_WORK, w);
    expect_window(p, p + 30, "pause_hold", S_PAUSE, 0);
    repeat (6) @(negedge clk);
    f_start = 1'b1;
    wait_until(p + 30);

    // Start -> WORK again: next tick after the remaining 6 counts
    f_start = 1'b0;
    q = cyc + 1 + LAT;
    w2 = q - 4;
    expect_window(cyc + 1, q - 1, "resume_pre", S_PAUSE, 0);
    expect_window(q, q + 17, "resume_ticks", S_WORK, w2);
    repeat (6) @(negedge clk);
    f_start = 1'b1;
    wait_until(q + 17);

    // Stop and Record together: IDLE + clear + drop, no record strobe
    wait_phase(w2, 5);
    f_stop = 1'b0;
    f_record = 1'b0;
    s = cyc + 1 + LAT;
    expect_window(cyc + 1, s - 1, "stoprec_pre", S_WORK, w2);
    push_exp(s, "stop_rec_drop", 7'h7F, ev(S_IDLE, 1'b0, 1'b1, 1'b0, 1'b1));
    expect_window(s + 1, s + 5, "stoprec_post", S_IDLE, 0);
    repeat (6) @(negedge clk);
    f_stop = 1'b1;
    f_record = 1'b1;
    wait_until(s + 8);

    // Record in IDLE: nothing at all
    f_record = 1'b0;
    r = cyc + 1 + LAT;
    expect_window(cyc + 1, r + 4, "rec_in_idle", S_IDLE, 0);
    repeat (6) @(negedge clk);
    f_record = 1'b1;
    wait_until(r + 8);

`ifdef DEBOUNCE_EN
    // 3-cycle glitch is filtered
    f_start = 1'b0;
    g = cyc + 1;
    expect_window(g, g + LAT + 6, "glitch_filtered", S_IDLE, 0);
    repeat (3) @(negedge clk);
    f_start = 1'b1;
    wait_until(g + LAT + 8);
`else
    // 1-cycle glitch is a command without the filter
    f_start = 1'b0;
    g = cyc + 1 + LAT;
    expect_window(cyc + 1, g - 1, "glitch_pre", S_IDLE, 0);
    expect_window(g, g + 3, "glitch_passes", S_WORK, g);
    @(negedge clk);
    f_start = 1'b1;
    wait_until(g + 4);
    wait_phase(g, 5);
    f_stop = 1'b0;
    s = cyc + 1 + LAT;
    expect_window(cyc + 1, s - 1, "glitch_stop_pre", S_WORK, g);
    push_exp(s, "glitch_stop", 7'h7F, ev(S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0));
    expect_window(s + 1, s + 4, "glitch_stop_post", S_IDLE, 0);
    repeat (6) @(negedge clk);
    f_stop = 1'b1;
    wait_until(s + 8);
`endif

    // Start held through reset and after release: stays IDLE
    f_start = 1'b0;
    rst = 1'b1;
    expect_window(cyc + 1, cyc + 23, "held_thru_rst", S_IDLE, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    f_start = 1'b1;
    expect_window(cyc + 1, cyc + 12, "held_release", S_IDLE, 0);
    repeat (12) @(negedge clk);

    // re-press is accepted
    f_start = 1'b0;
    w3 = cyc + 1 + LAT;
    expect_window(cyc + 1, w3 - 1, "repress_pre", S_IDLE, 0);
    expect_window(w3, w3 + 8, "repress_work", S_WORK, w3);
    repeat (6) @(negedge clk);
    f_start = 1'b1;
    wait_until(w3 + 8);

    // PAUSE with prescaler at 6, then reset
    wait_phase(w3, 6);
    f_start = 1'b0;
    p3 = cyc + 1 + LAT;
    expect_window(cyc + 1, p3 - 1, "pause6_pre", S_WORK, w3);
    expect_window(p3, p3 + 3, "pause6", S_PAUSE, 0);
    repeat (6) @(negedge clk);
    f_start = 1'b1;
    wait_until(p3 + 3);
    rst = 1'b1;
    k = cyc + 1;
    push_exp(k, "rst_in_pause", 7'h7F, ev(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    expect_window(cyc + 1, cyc + 5, "after_rst_pause", S_IDLE, 0);
    repeat (5) @(negedge clk);

    // first tick after a full TICK_DIV cycles
    f_start = 1'b0;
    q3 = cyc + 1 + LAT;
    expect_window(cyc + 1, q3 - 1, "restart_pre", S_IDLE, 0);
    expect_window(q3, q3 + 11, "full_tick_after_rst", S_WORK, q3);
    repeat (6) @(negedge clk);
    f_start = 1'b1;
    wait_until(q3 + 12);

    repeat (2) @(negedge clk);
    check_eq("sb_drain", sb.size(), 32'd0);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
